// File: rtl/ctrl_contador.sv
//------------------------------------------------------------------------------
// Module   : ctrl_contador
// Purpose  : Round-robin sequencer for one 4-bit mode counter; runs load+step
//            commands from two requesters and reports final Q and RCO count.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ctrl_contador #(
  parameter int SW = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [1:0]      REQ_VALID,
  input  logic [3:0]      REQ_MODO,
  input  logic [7:0]      REQ_D,
  input  logic [2*SW-1:0] REQ_STEPS,
  output logic [1:0]      REQ_READY,
  output logic            CNT_ENB,
  output logic [1:0]      CNT_MODO,
  output logic [3:0]      CNT_D,
  input  logic [3:0]      CNT_Q,
  input  logic            CNT_RCO,
  output logic            BUSY,
  output logic            DONE,
  output logic            DONE_ID,
  output logic [3:0]      RESULT,
  output logic [SW-1:0]   WRAPS
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_rr;
  logic          r_id;
  logic [1:0]    r_modo;
  logic [3:0]    r_d;
  logic [SW-1:0] r_steps;
  logic [SW-1:0] r_acc;
  logic [1:0]    w_grant;
  logic          w_gid;
  logic [SW-1:0] w_acc_nxt;

  assign w_gid     = w_grant[1];
  assign REQ_READY = w_grant;
  assign BUSY      = (r_state != S_IDLE);
  assign DONE      = (r_state == S_DONE);

  // RCO accumulator saturates instead of wrapping
  assign w_acc_nxt = (CNT_RCO && (r_acc != {SW{1'b1}})) ? r_acc + 1'b1 : r_acc;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 2'b00;
    CNT_ENB     = 1'b0;
    CNT_MODO    = 2'b00;
    CNT_D       = 4'd0;
    case (r_state)
      S_IDLE: begin
        if (!RESET) begin
          if (REQ_VALID == 2'b11)
            w_grant = r_rr ? 2'b10 : 2'b01;
          else
            w_grant = REQ_VALID;
        end
        if (w_grant != 2'b00)
          w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        CNT_ENB  = 1'b1;
        CNT_MODO = 2'b11;
        CNT_D    = r_d;
        if ((r_steps != {SW{1'b0}}) && (r_modo != 2'b11))
          w_state_nxt = S_RUN;
        else
          w_state_nxt = S_DRAIN;
      end
      S_RUN: begin
        CNT_ENB  = 1'b1;
        CNT_MODO = r_modo;
        if (r_steps == {{(SW-1){1'b0}}, 1'b1})
          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_rr    <= 1'b0;
      r_id    <= 1'b0;
      r_modo  <= 2'b00;
      r_d     <= 4'd0;
      r_steps <= {SW{1'b0}};
      r_acc   <= {SW{1'b0}};
      DONE_ID <= 1'b0;
      RESULT  <= 4'd0;
      WRAPS   <= {SW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if (w_grant != 2'b00) begin
        r_id    <= w_gid;
        r_rr    <= ~w_gid;
        r_modo  <= w_gid ? REQ_MODO[3:2] : REQ_MODO[1:0];
        r_d     <= w_gid ? REQ_D[7:4]    : REQ_D[3:0];
        r_steps <= w_gid ? REQ_STEPS[2*SW-1:SW] : REQ_STEPS[SW-1:0];
        r_acc   <= {SW{1'b0}};
      end
      if (r_state == S_RUN)
        r_steps <= r_steps - 1'b1;
      if ((r_state == S_RUN) || (r_state == S_DRAIN))
        r_acc <= w_acc_nxt;
      // Published results change only here, so they stay stable until the next DONE
      if (r_state == S_DRAIN) begin
        RESULT  <= CNT_Q;
        WRAPS   <= w_acc_nxt;
        DONE_ID <= r_id;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ctrl_contador.sv
//------------------------------------------------------------------------------
// Module   : tb_ctrl_contador
// Purpose  : Directed bench for ctrl_contador with a behavioural mode counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ctrl_contador;

  localparam int SW = 4;

  logic            CLK = 1'b0;
  logic            RESET = 1'b1;
  logic [1:0]      REQ_VALID = 2'b00;
  logic [3:0]      REQ_MODO = 4'd0;
  logic [7:0]      REQ_D = 8'd0;
  logic [2*SW-1:0] REQ_STEPS = '0;
  logic [1:0]      REQ_READY;
  logic            CNT_ENB;
  logic [1:0]      CNT_MODO;
  logic [3:0]      CNT_D;
  logic [3:0]      CNT_Q = 4'd0;
  logic            CNT_RCO = 1'b0;
  logic            BUSY;
  logic            DONE;
  logic            DONE_ID;
  logic [3:0]      RESULT;
  logic [SW-1:0]   WRAPS;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_acc = 0;

  ctrl_contador #(.SW(SW)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_MODO(REQ_MODO), .REQ_D(REQ_D), .REQ_STEPS(REQ_STEPS),
    .REQ_READY(REQ_READY),
    .CNT_ENB(CNT_ENB), .CNT_MODO(CNT_MODO), .CNT_D(CNT_D), .CNT_Q(CNT_Q), .CNT_RCO(CNT_RCO),
    .BUSY(BUSY), .DONE(DONE), .DONE_ID(DONE_ID), .RESULT(RESULT), .WRAPS(WRAPS)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Mode counter: RCO flags the step that wraps and appears with the new Q
  always @(posedge CLK) begin
    if (CNT_ENB) begin
      case (CNT_MODO)
        2'b00: begin CNT_Q <= CNT_Q + 4'd1; CNT_RCO <= (CNT_Q == 4'hF); end
        2'b01: begin CNT_Q <= CNT_Q - 4'd1; CNT_RCO <= (CNT_Q == 4'h0); end
        2'b10: begin CNT_Q <= CNT_Q - 4'd3; CNT_RCO <= 1'b0; end
        default: begin CNT_Q <= CNT_D; CNT_RCO <= 1'b0; end
      endcase
    end else begin
      CNT_RCO <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int id, input logic [1:0] modo, input logic [3:0] d,
                      input logic [SW-1:0] steps);
    bit got = 1'b0;
    REQ_MODO[2*id +: 2]    = modo;
    REQ_D[4*id +: 4]       = d;
    REQ_STEPS[SW*id +: SW] = steps;
    REQ_VALID[id]          = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      if (REQ_VALID[id] && REQ_READY[id]) begin
        got   = 1'b1;
        t_acc = cyc;
      end
    end
    chk("accept", {31'd0, got}, 32'd1);
    chk("ready_onehot", {30'd0, REQ_READY}, 32'd1 << id);
    @(posedge CLK);
    #1;
    REQ_VALID[id] = 1'b0;
  endtask

  task automatic finish_cmd(input int id, input logic [3:0] res, input logic [SW-1:0] wr,
                            input int lat, input int enb_exp);
    bit got = 1'b0;
    int enb = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge CLK);
      if (CNT_ENB) enb++;
      if (DONE) got = 1'b1;
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    chk("latency", cyc - t_acc, lat);
    chk("enb_cycles", enb, enb_exp);
    chk("done_id", {31'd0, DONE_ID}, id);
    chk("result", {28'd0, RESULT}, {28'd0, res});
    chk("wraps", {28'd0, WRAPS}, {28'd0, wr});
    chk("busy_in_done", {31'd0, BUSY}, 32'd1);
    chk("ready_in_done", {30'd0, REQ_READY}, 32'd0);
    @(negedge CLK);
    chk("done_pulse", {31'd0, DONE}, 32'd0);
    chk("result_hold", {28'd0, RESULT}, {28'd0, res});
    chk("busy_after", {31'd0, BUSY}, 32'd0);
  endtask

  initial begin
    bit got;
    int seen;

    // 1: reset for two cycles with no requests
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ready", {30'd0, REQ_READY}, 32'd0);
    chk("rst_enb", {31'd0, CNT_ENB}, 32'd0);
    chk("rst_modo", {30'd0, CNT_MODO}, 32'd0);
    chk("rst_d", {28'd0, CNT_D}, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_done_id", {31'd0, DONE_ID}, 32'd0);
    chk("rst_result", {28'd0, RESULT}, 32'd0);
    chk("rst_wraps", {28'd0, WRAPS}, 32'd0);
    RESET = 1'b0;

    // 2: up from E for 3 steps wraps once
    send(0, 2'b00, 4'hE, 4'd3);
    finish_cmd(0, 4'h1, 4'd1, 6, 4);

    // 3: down from 1 for 4 steps, then minus-3 from 2
    send(1, 2'b01, 4'h1, 4'd4);
    finish_cmd(1, 4'hD, 4'd1, 7, 5);
    send(0, 2'b10, 4'h2, 4'd2);
    finish_cmd(0, 4'hC, 4'd0, 5, 3);

    // 4: load-only command and zero-step command skip RUN
    send(0, 2'b11, 4'h7, 4'd5);
    finish_cmd(0, 4'h7, 4'd0, 3, 1);
    send(0, 2'b00, 4'h7, 4'd0);
    finish_cmd(0, 4'h7, 4'd0, 3, 1);

    // 5: both requesters held valid after a reset alternate 0,1,0,1
    @(posedge CLK); #1; RESET = 1'b1;
    @(posedge CLK); #1; RESET = 1'b0;
    REQ_MODO  = {2'b01, 2'b00};
    REQ_D     = {4'h3, 4'h3};
    REQ_STEPS = {4'd1, 4'd2};
    REQ_VALID = 2'b11;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge CLK);
        if ((REQ_VALID & REQ_READY) != 2'b00) got = 1'b1;
      end
      chk("rr_accept", {31'd0, got}, 32'd1);
      chk("rr_grant", {30'd0, REQ_READY}, (k % 2) ? 32'd2 : 32'd1);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge CLK);
        if (DONE) got = 1'b1;
      end
      chk("rr_done", {31'd0, got}, 32'd1);
      chk("rr_done_id", {31'd0, DONE_ID}, k % 2);
      chk("rr_result", {28'd0, RESULT}, (k % 2) ? 32'd2 : 32'd5);
    end
    REQ_VALID = 2'b00;
    repeat (2) @(negedge CLK);

    // 6: reset in the second RUN cycle aborts without DONE
    send(0, 2'b00, 4'h0, 4'd8);
    @(posedge CLK);
    @(posedge CLK); #1; RESET = 1'b1;
    @(posedge CLK); #1; RESET = 1'b0;
    @(negedge CLK);
    chk("abort_busy", {31'd0, BUSY}, 32'd0);
    chk("abort_enb", {31'd0, CNT_ENB}, 32'd0);
    chk("abort_done", {31'd0, DONE}, 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (DONE || BUSY) seen++;
    end
    chk("abort_quiet", seen, 32'd0);
    send(0, 2'b00, 4'h0, 4'd8);
    finish_cmd(0, 4'h8, 4'd0, 11, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
